// File: rtl/cosim_commit_queue.sv
// cosim_commit_queue
// Buffers retire records from the core so a co-simulation checker can
// consume them at its own pace. Every retire attempt is stamped with a
// 32-bit sequence number. A push that finds the queue full is dropped and
// recorded in a sticky flag and a saturating counter, and it still uses up
// a sequence number, so the checker sees a gap where commits were lost.
// stall_o asks the core to pause retirement once occupancy reaches AF_TH.
//
// Handshake: chk_valid_o is high whenever the queue holds an entry, and the
// head fields are valid while it is high. The head is consumed on a rising
// edge where chk_valid_o && chk_ready_i && !clear_i. chk_valid_o never
// depends on chk_ready_i, and no input reaches an output combinationally.
module cosim_commit_queue #(
   parameter int DEPTH = 16,
   parameter int AF_TH = 12
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     enable_i,
   input  logic                     clear_i,
   input  logic                     commit_valid_i,
   input  logic [63:0]              commit_pc_i,
   input  logic [31:0]              commit_ins_i,
   input  logic [4:0]               commit_dst_i,
   input  logic                     commit_wr_valid_i,
   input  logic [63:0]              commit_data_i,
   input  logic                     commit_xcpt_i,
   input  logic [63:0]              commit_cause_i,
   output logic                     chk_valid_o,
   input  logic                     chk_ready_i,
   output logic [63:0]              chk_pc_o,
   output logic [31:0]              chk_ins_o,
   output logic [4:0]               chk_dst_o,
   output logic                     chk_wr_valid_o,
   output logic [63:0]              chk_data_o,
   output logic                     chk_xcpt_o,
   output logic [63:0]              chk_cause_o,
   output logic [31:0]              chk_seq_o,
   output logic                     stall_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     overflow_o,
   output logic [15:0]              drop_cnt_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   // Thresholds held at count width so every comparison is width-matched.
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C    = CW'(AF_TH);

   // Record storage. Each field has its own array; none of it is reset,
   // because the head fields are meaningless while the queue is empty.
   logic [63:0] pc_mem    [DEPTH];
   logic [31:0] ins_mem   [DEPTH];
   logic [4:0]  dst_mem   [DEPTH];
   logic        wr_mem    [DEPTH];
   logic [63:0] data_mem  [DEPTH];
   logic        xcpt_mem  [DEPTH];
   logic [63:0] cause_mem [DEPTH];
   logic [31:0] seq_mem   [DEPTH];

   // Control state.
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count_q;
   logic [CW-1:0] count_nxt;
   logic [31:0]   seq_q;
   logic          stall_q;
   logic          overflow_q;
   logic [15:0]   drop_q;

   // Per-cycle decisions.
   logic push_try;
   logic pop;
   logic full;
   logic push;
   logic drop;
   logic head_valid;

   // A flush cycle suppresses both sides of the queue; it is not a drop.
   assign push_try   = commit_valid_i & enable_i & ~clear_i;
   assign head_valid = (count_q != '0);
   assign pop        = head_valid & chk_ready_i & ~clear_i;
   assign full       = (count_q == DEPTH_C);
   // When full, a same-cycle pop frees the slot that the push then takes.
   assign push       = push_try & (~full | pop);
   assign drop       = push_try & ~push;

   // Next occupancy; stall_o is registered from this post-update value.
   always_comb begin
      count_nxt = count_q;
      if (clear_i) begin
         count_nxt = '0;
      end else begin
         unique case ({push, pop})
            2'b10:   count_nxt = count_q + CW'(1);
            2'b01:   count_nxt = count_q - CW'(1);
            default: count_nxt = count_q;
         endcase
      end
   end

   // Pointers and occupancy; pointers wrap naturally since DEPTH is 2^PW.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else if (clear_i) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         count_q <= count_nxt;
      end
   end

   // Sequence counter advances on every attempt, accepted or dropped, so
   // lost commits leave a gap; a flush leaves it untouched.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seq_q <= '0;
      end else if (push_try) begin
         seq_q <= seq_q + 32'd1;
      end
   end

   // Sticky overflow (cleared by flush) and saturating drop counter
   // (kept across flush so the checker can still see the total loss).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow_q <= 1'b0;
         drop_q     <= '0;
      end else if (clear_i) begin
         overflow_q <= 1'b0;
      end else if (drop) begin
         overflow_q <= 1'b1;
         if (drop_q != 16'hFFFF) begin
            drop_q <= drop_q + 16'd1;
         end
      end
   end

   // Almost-full stall request, registered from the next occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q <= 1'b0;
      end else begin
         stall_q <= (count_nxt >= AF_C);
      end
   end

   // Record write at the tail slot on an accepted push.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr]    <= commit_pc_i;
         ins_mem[wr_ptr]   <= commit_ins_i;
         dst_mem[wr_ptr]   <= commit_dst_i;
         wr_mem[wr_ptr]    <= commit_wr_valid_i;
         data_mem[wr_ptr]  <= commit_data_i;
         xcpt_mem[wr_ptr]  <= commit_xcpt_i;
         cause_mem[wr_ptr] <= commit_cause_i;
         seq_mem[wr_ptr]   <= seq_q;
      end
   end

   // Head fields come straight from storage at the read pointer.
   assign chk_valid_o    = head_valid;
   assign chk_pc_o       = pc_mem[rd_ptr];
   assign chk_ins_o      = ins_mem[rd_ptr];
   assign chk_dst_o      = dst_mem[rd_ptr];
   assign chk_wr_valid_o = wr_mem[rd_ptr];
   assign chk_data_o     = data_mem[rd_ptr];
   assign chk_xcpt_o     = xcpt_mem[rd_ptr];
   assign chk_cause_o    = cause_mem[rd_ptr];
   assign chk_seq_o      = seq_mem[rd_ptr];

   // Status outputs.
   assign count_o    = count_q;
   assign stall_o    = stall_q;
   assign overflow_o = overflow_q;
   assign drop_cnt_o = drop_q;

endmodule

// File: tb/tb_cosim_commit_queue.sv
// Testbench for cosim_commit_queue: directed scenarios followed by random
// traffic, checked against a queue-based reference model.
module tb_cosim_commit_queue;

   localparam int DEPTH = 16;
   localparam int AF_TH = 12;
   localparam int CW    = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] ins;
      logic [4:0]  dst;
      logic        wr;
      logic [63:0] data;
      logic        xcpt;
      logic [63:0] cause;
      logic [31:0] seq;
   } rec_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          enable_i;
   logic          clear_i;
   logic          commit_valid_i;
   logic [63:0]   commit_pc_i;
   logic [31:0]   commit_ins_i;
   logic [4:0]    commit_dst_i;
   logic          commit_wr_valid_i;
   logic [63:0]   commit_data_i;
   logic          commit_xcpt_i;
   logic [63:0]   commit_cause_i;
   logic          chk_valid_o;
   logic          chk_ready_i;
   logic [63:0]   chk_pc_o;
   logic [31:0]   chk_ins_o;
   logic [4:0]    chk_dst_o;
   logic          chk_wr_valid_o;
   logic [63:0]   chk_data_o;
   logic          chk_xcpt_o;
   logic [63:0]   chk_cause_o;
   logic [31:0]   chk_seq_o;
   logic          stall_o;
   logic [CW-1:0] count_o;
   logic          overflow_o;
   logic [15:0]   drop_cnt_o;

   cosim_commit_queue #(.DEPTH(DEPTH), .AF_TH(AF_TH)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .enable_i          (enable_i),
      .clear_i           (clear_i),
      .commit_valid_i    (commit_valid_i),
      .commit_pc_i       (commit_pc_i),
      .commit_ins_i      (commit_ins_i),
      .commit_dst_i      (commit_dst_i),
      .commit_wr_valid_i (commit_wr_valid_i),
      .commit_data_i     (commit_data_i),
      .commit_xcpt_i     (commit_xcpt_i),
      .commit_cause_i    (commit_cause_i),
      .chk_valid_o       (chk_valid_o),
      .chk_ready_i       (chk_ready_i),
      .chk_pc_o          (chk_pc_o),
      .chk_ins_o         (chk_ins_o),
      .chk_dst_o         (chk_dst_o),
      .chk_wr_valid_o    (chk_wr_valid_o),
      .chk_data_o        (chk_data_o),
      .chk_xcpt_o        (chk_xcpt_o),
      .chk_cause_o       (chk_cause_o),
      .chk_seq_o         (chk_seq_o),
      .stall_o           (stall_o),
      .count_o           (count_o),
      .overflow_o        (overflow_o),
      .drop_cnt_o        (drop_cnt_o)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- counters and compare helper ----------------
   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [262:0] act, input logic [262:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model / scoreboard ----------------
   // exp_q holds the records the queue should contain, oldest first.
   rec_t        exp_q[$];
   logic [31:0] m_seq;
   logic [15:0] m_drop;
   logic        m_ovf;
   logic        m_stall;

   // Monitor: on each falling edge compare the DUT against the model, then
   // advance the model by the inputs that the next rising edge will see.
   always @(negedge clk) begin
      rec_t r;
      rec_t h;
      bit   do_pop;
      bit   attempt;
      if (!rst_n) begin
         exp_q.delete();
         m_seq   = '0;
         m_drop  = '0;
         m_ovf   = 1'b0;
         m_stall = 1'b0;
      end else begin
         chk("count", count_o, exp_q.size());
         chk("valid", chk_valid_o, exp_q.size() != 0);
         chk("stall", stall_o, m_stall);
         chk("overflow", overflow_o, m_ovf);
         chk("drop_cnt", drop_cnt_o, m_drop);
         if (exp_q.size() != 0) begin
            h = exp_q[0];
            chk("head_seq", chk_seq_o, h.seq);
            chk("head_fields",
                {chk_pc_o, chk_ins_o, chk_dst_o, chk_wr_valid_o, chk_data_o, chk_xcpt_o, chk_cause_o},
                {h.pc, h.ins, h.dst, h.wr, h.data, h.xcpt, h.cause});
         end
         do_pop  = (exp_q.size() != 0) && chk_ready_i && !clear_i;
         attempt = commit_valid_i && enable_i && !clear_i;
         if (clear_i) begin
            exp_q.delete();
            m_ovf = 1'b0;
         end else begin
            if (do_pop) void'(exp_q.pop_front());
            if (attempt) begin
               if (exp_q.size() < DEPTH) begin
                  r = '{pc: commit_pc_i, ins: commit_ins_i, dst: commit_dst_i,
                        wr: commit_wr_valid_i, data: commit_data_i, xcpt: commit_xcpt_i,
                        cause: commit_cause_i, seq: m_seq};
                  exp_q.push_back(r);
               end else begin
                  m_ovf = 1'b1;
                  if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
               end
               m_seq = m_seq + 32'd1;
            end
         end
         m_stall = (exp_q.size() >= AF_TH);
      end
   end

   // ---------------- driver tasks ----------------
   // Sets inputs just after a rising edge; they take effect at the next one.
   task automatic step(input bit cv, input bit en, input bit clr, input bit rdy);
      @(posedge clk);
      #1;
      commit_valid_i    = cv;
      enable_i          = en;
      clear_i           = clr;
      chk_ready_i       = rdy;
      commit_pc_i       = {$urandom, $urandom};
      commit_ins_i      = $urandom;
      commit_dst_i      = 5'($urandom);
      commit_wr_valid_i = 1'($urandom);
      commit_data_i     = {$urandom, $urandom};
      commit_xcpt_i     = 1'($urandom);
      commit_cause_i    = {$urandom, $urandom};
   endtask

   // Asserts reset between edges and checks the outputs drop at once.
   task automatic async_reset();
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("rst_count", count_o, 0);
      chk("rst_valid", chk_valid_o, 0);
      chk("rst_stall", stall_o, 0);
      chk("rst_overflow", overflow_o, 0);
      chk("rst_drop", drop_cnt_o, 0);
      commit_valid_i = 1'b0;
      clear_i        = 1'b0;
      chk_ready_i    = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst_n             = 1'b0;
      enable_i          = 1'b1;
      clear_i           = 1'b0;
      commit_valid_i    = 1'b0;
      chk_ready_i       = 1'b0;
      commit_pc_i       = '0;
      commit_ins_i      = '0;
      commit_dst_i      = '0;
      commit_wr_valid_i = 1'b0;
      commit_data_i     = '0;
      commit_xcpt_i     = 1'b0;
      commit_cause_i    = '0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Single push becomes visible the following cycle.
      step(1, 1, 0, 0);
      commit_pc_i  = 64'h0000_0000_8000_0000;
      commit_ins_i = 32'h0000_0013;
      step(0, 1, 0, 0);
      chk("single_valid", chk_valid_o, 1);
      chk("single_pc", chk_pc_o, 64'h8000_0000);
      chk("single_ins", chk_ins_o, 32'h13);
      chk("single_seq", chk_seq_o, 0);
      chk("single_count", count_o, 1);
      async_reset();

      // Fill, almost-full stall, overflow, gap in sequence, then flush.
      repeat (12) step(1, 1, 0, 0);
      step(1, 1, 0, 0);
      chk("af_stall", stall_o, 1);
      chk("af_count", count_o, 12);
      repeat (3) step(1, 1, 0, 0);
      step(1, 1, 0, 0);
      chk("full_count", count_o, 16);
      chk("full_ovf_before", overflow_o, 0);
      step(0, 1, 0, 0);
      chk("ovf_set", overflow_o, 1);
      chk("ovf_drop", drop_cnt_o, 1);
      step(0, 1, 0, 1);
      step(1, 1, 0, 0);
      step(0, 1, 0, 0);
      chk("refill_count", count_o, 16);
      repeat (11) step(0, 1, 0, 1);
      step(1, 1, 1, 0);
      chk("pre_clear_count", count_o, 5);
      chk("pre_clear_ovf", overflow_o, 1);
      step(0, 1, 0, 0);
      chk("clear_count", count_o, 0);
      chk("clear_ovf", overflow_o, 0);
      chk("clear_drop", drop_cnt_o, 1);
      step(1, 1, 0, 0);
      step(0, 1, 0, 0);
      chk("post_clear_seq", chk_seq_o, 18);
      async_reset();

      // Full queue with simultaneous push and pop.
      repeat (16) step(1, 1, 0, 0);
      step(1, 1, 0, 1);
      step(0, 1, 0, 0);
      chk("pp_count", count_o, 16);
      chk("pp_drop", drop_cnt_o, 0);
      chk("pp_head_seq", chk_seq_o, 1);
      repeat (16) step(0, 1, 0, 1);
      async_reset();

      // Streaming push+pop across pointer wrap.
      repeat (40) step(1, 1, 0, 1);
      step(0, 1, 0, 0);
      chk("stream_count", count_o, 1);
      chk("stream_seq", chk_seq_o, 39);
      async_reset();

      // enable low blocks pushes without using sequence numbers.
      step(1, 0, 0, 0);
      step(1, 1, 0, 0);
      step(0, 1, 0, 0);
      chk("en_seq", chk_seq_o, 0);
      async_reset();

      // Asynchronous reset with eight entries queued.
      repeat (8) step(1, 1, 0, 0);
      step(0, 1, 0, 0);
      chk("pre_rst_count", count_o, 8);
      async_reset();

      // Random traffic, alternating between slow and fast checker phases.
      for (int i = 0; i < 3000; i++) begin
         int rdy_pct;
         rdy_pct = ((i / 300) % 2 == 0) ? 25 : 80;
         if ($urandom_range(0, 999) < 2) begin
            async_reset();
         end else begin
            step($urandom_range(0, 9) < 7,
                 $urandom_range(0, 9) != 0,
                 $urandom_range(0, 99) < 2,
                 $urandom_range(0, 99) < rdy_pct);
         end
      end
      repeat (4) step(0, 1, 0, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/cosim_commit_queue.md
COSIM_COMMIT_QUEUE -- requirements
Module: cosim_commit_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries (power of two, >= 4).
REQ-002 SHALL have parameter AF_TH, default 12, almost-full threshold in entries (1..DEPTH).
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port enable_i, input, 1, cosim capture enable.
REQ-006 SHALL have port clear_i, input, 1, synchronous queue flush.
REQ-007 SHALL have port commit_valid_i, input, 1, core retired one instruction this cycle.
REQ-008 SHALL have ports commit_pc_i (64), commit_ins_i (32), commit_dst_i (5), commit_wr_valid_i (1), commit_data_i (64), commit_xcpt_i (1), commit_cause_i (64), all inputs, retire record fields.
REQ-009 SHALL have port chk_valid_o, output, 1, head entry available to checker.
REQ-010 SHALL have port chk_ready_i, input, 1, checker consumes head.
REQ-011 SHALL have ports chk_pc_o, chk_ins_o, chk_dst_o, chk_wr_valid_o, chk_data_o, chk_xcpt_o, chk_cause_o, outputs, widths as REQ-008, head record fields.
REQ-012 SHALL have port chk_seq_o, output, 32, retire sequence number of head.
REQ-013 SHALL have port stall_o, output, 1, request core retire stall.
REQ-014 SHALL have port count_o, output, $clog2(DEPTH)+1, occupancy.
REQ-015 SHALL have port overflow_o, output, 1, sticky lost-commit flag.
REQ-016 SHALL have port drop_cnt_o, output, 16, dropped-commit count.

Function
REQ-017 Push attempt SHALL be commit_valid_i && enable_i && !clear_i.
REQ-018 Push SHALL be accepted when count < DEPTH, or when count == DEPTH and a pop occurs the same cycle.
REQ-019 Pop SHALL occur when chk_valid_o && chk_ready_i && !clear_i.
REQ-020 chk_valid_o SHALL equal (count != 0); head fields SHALL be driven from storage at the read pointer (no output register).
REQ-021 Entry accepted at edge N SHALL appear on chk_valid_o/head fields after edge N (visible in cycle N+1 if queue was empty); no combinational input-to-output path.
REQ-022 Each accepted push SHALL store the current 32-bit seq counter value, then increment it; wraps 0xFFFFFFFF -> 0.
REQ-023 Rejected push attempt (full, no pop) SHALL set overflow_o and increment drop_cnt_o, saturating at 0xFFFF; seq counter SHALL still increment, leaving a visible gap in chk_seq_o.
REQ-024 Simultaneous accepted push and pop SHALL leave count unchanged; both pointers advance, wrapping modulo DEPTH.
REQ-025 stall_o SHALL be registered, equal to (count >= AF_TH) evaluated on the post-update count.
REQ-026 clear_i SHALL reset pointers, count, overflow_o to 0 next edge; push and pop same cycle SHALL be ignored and not counted as drops; seq counter and drop_cnt_o SHALL be preserved.
REQ-027 enable_i low SHALL block pushes only; pops continue; seq counter not incremented.
REQ-028 Entries SHALL be popped strictly in push order.

Reset
REQ-029 On rst_n low, asynchronously: count_o=0, chk_valid_o=0, stall_o=0, overflow_o=0, drop_cnt_o=0, seq counter=0, pointers=0.
REQ-030 Storage array SHALL NOT require reset; head fields are don't-care while chk_valid_o=0.
REQ-031 Reset asserted mid-operation SHALL discard all queued entries; first push after deassertion carries seq 0.

Verification
REQ-032 Single push pc=0x80000000, ins=0x00000013, chk_ready_i=0 -> next cycle chk_valid_o=1, chk_pc_o=0x80000000, chk_seq_o=0, count_o=1.
REQ-033 Fill 16 pushes, ready=0 (defaults) -> stall_o=1 after 12th push, count_o=16; 17th push -> overflow_o=1, drop_cnt_o=1; next accepted entry seq=17.
REQ-034 Full queue, push and pop same cycle -> count_o stays 16, no drop, popped seq=0, new tail seq=16.
REQ-035 Continuous push+pop for 40 cycles -> chk_seq_o increments 0..39 in order, pointer wrap exercised, count_o constant 1.
REQ-036 count=5, overflow_o=1, assert clear_i with commit_valid_i=1 -> next cycle count_o=0, overflow_o=0, drop_cnt_o unchanged, seq counter unchanged.
REQ-037 Assert rst_n=0 asynchronously with count=8 -> outputs zero immediately, before next clk edge.
